// File: rtl/dram_ctrl_pkg.sv
// Shared types for the DRAM AXI traffic gate: gate FSM states, drain return
// targets and the default AXI request/response structs used on the MIG port.
package dram_ctrl_pkg;

  localparam int unsigned AxiIdW   = 4;
  localparam int unsigned AxiAddrW = 32;
  localparam int unsigned AxiDataW = 32;
  localparam int unsigned AxiStrbW = AxiDataW / 8;

  typedef enum logic [1:0] {
    CALIB   = 2'd0,
    RUN     = 2'd1,
    DRAIN   = 2'd2,
    DRAINED = 2'd3
  } gate_state_e;

  typedef enum logic {
    RET_CALIB   = 1'b0,
    RET_DRAINED = 1'b1
  } drain_ret_e;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiAddrW-1:0] addr;
    logic [7:0]          len;
  } dram_ax_chan_t;

  typedef struct packed {
    logic [AxiDataW-1:0] data;
    logic [AxiStrbW-1:0] strb;
    logic                last;
  } dram_w_chan_t;

  typedef struct packed {
    logic [AxiIdW-1:0] id;
    logic [1:0]        resp;
  } dram_b_chan_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiDataW-1:0] data;
    logic [1:0]          resp;
    logic                last;
  } dram_r_chan_t;

  typedef struct packed {
    dram_ax_chan_t aw;
    logic          aw_valid;
    dram_w_chan_t  w;
    logic          w_valid;
    logic          b_ready;
    dram_ax_chan_t ar;
    logic          ar_valid;
    logic          r_ready;
  } dram_axi_req_t;

  typedef struct packed {
    logic         aw_ready;
    logic         ar_ready;
    logic         w_ready;
    logic         b_valid;
    dram_b_chan_t b;
    logic         r_valid;
    dram_r_chan_t r;
  } dram_axi_resp_t;

endpackage

// File: rtl/dram_txn_counter.sv
// Saturation-free up/down transaction counter; simultaneous inc and dec hold
// the value. zero_next lets the drain logic react in the same cycle.
module dram_txn_counter #(
  parameter int unsigned Max   = 8,
  parameter int unsigned Width = $clog2(Max + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [Width-1:0] o_count,
  output logic             o_at_max,
  output logic             o_is_zero,
  output logic             o_zero_next
);

  logic [Width-1:0] r_count;
  logic [Width-1:0] w_count_next;

  always_comb begin
    w_count_next = r_count;
    if (i_inc && !i_dec) begin
      w_count_next = r_count + Width'(1);
    end else if (i_dec && !i_inc) begin
      w_count_next = r_count - Width'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_count     = r_count;
  assign o_at_max    = (r_count == Width'(Max));
  assign o_is_zero   = (r_count == '0);
  assign o_zero_next = (w_count_next == '0);

  // The gating upstream makes both of these impossible.
  a_no_overflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_inc && !i_dec && o_at_max));
  a_no_underflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_dec && !i_inc && o_is_zero));

endmodule

// File: rtl/dram_traffic_gate.sv
// AXI valid/ready gate in front of the MIG: waits for stable calibration,
// bounds outstanding bursts and quiesces the port on a drain request.
//
// Handshake rule: a channel beat transfers on a clock edge where valid and
// ready are both high; once the gate presents valid to the MIG it keeps it
// open (sticky grant) until that beat transfers, so valid never retracts.
module dram_traffic_gate
  import dram_ctrl_pkg::*;
#(
  parameter type         axi_req_t         = dram_axi_req_t,
  parameter type         axi_resp_t        = dram_axi_resp_t,
  parameter int unsigned MaxReadTxns       = 8,
  parameter int unsigned MaxWriteTxns      = 8,
  parameter int unsigned CalibStableCycles = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  axi_req_t                              slv_req_i,
  output axi_resp_t                             slv_resp_o,
  output axi_req_t                              mst_req_o,
  input  axi_resp_t                             mst_resp_i,
  input  logic                                  calib_done_i,
  input  logic                                  drain_req_i,
  output logic                                  drain_ack_o,
  output logic                                  calib_lost_o,
  output logic [$clog2(MaxReadTxns+1)-1:0]      rd_outstanding_o,
  output logic [$clog2(MaxWriteTxns+1)-1:0]     wr_outstanding_o,
  output gate_state_e                           dbg_state_o
);

  localparam int unsigned RdW = $clog2(MaxReadTxns + 1);
  localparam int unsigned WrW = $clog2(MaxWriteTxns + 1);
  localparam int unsigned StW = $clog2(CalibStableCycles + 1);
  localparam logic [StW-1:0] StableLast = StW'(CalibStableCycles - 1);

  gate_state_e      r_state, w_state_next;
  drain_ret_e       r_ret, w_ret_next;
  logic             r_calib_lost, w_calib_lost_next;
  logic [StW-1:0]   r_stable_cnt, w_stable_next;
  logic             r_ar_sticky, r_aw_sticky;
  logic             w_ar_sticky_d, w_aw_sticky_d;

  logic             w_ar_open, w_aw_open, w_w_open;
  logic             w_ar_hs, w_aw_hs, w_w_last_hs, w_r_last_hs, w_b_hs;
  logic [RdW-1:0]   w_rd_cnt;
  logic [WrW-1:0]   w_wr_cnt, w_wp_cnt;
  logic             w_rd_at_max, w_wr_at_max, w_wp_at_max;
  logic             w_rd_zero, w_wr_zero, w_wp_zero;
  logic             w_rd_zero_next, w_wr_zero_next, w_wp_zero_next;
  logic             w_idle_next;

  // rst_ni is folded in so the gate is shut in the reset cycle itself.
  assign w_ar_open = rst_ni & (((r_state == RUN) & ~w_rd_at_max) | r_ar_sticky);
  assign w_aw_open = rst_ni & (((r_state == RUN) & ~w_wr_at_max) | r_aw_sticky);

  assign w_ar_hs = slv_req_i.ar_valid & mst_resp_i.ar_ready & w_ar_open;
  assign w_aw_hs = slv_req_i.aw_valid & mst_resp_i.aw_ready & w_aw_open;

  // W may only follow an AW the MIG has accepted, at the latest in the same cycle.
  assign w_w_open    = rst_ni & (~w_wp_zero | w_aw_hs);
  assign w_w_last_hs = slv_req_i.w_valid & mst_resp_i.w_ready & w_w_open & slv_req_i.w.last;
  assign w_r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
  assign w_b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;

  assign w_ar_sticky_d = slv_req_i.ar_valid & w_ar_open & ~mst_resp_i.ar_ready;
  assign w_aw_sticky_d = slv_req_i.aw_valid & w_aw_open & ~mst_resp_i.aw_ready;

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.ar_valid = slv_req_i.ar_valid & w_ar_open;
    mst_req_o.aw_valid = slv_req_i.aw_valid & w_aw_open;
    mst_req_o.w_valid  = slv_req_i.w_valid & w_w_open;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & w_ar_open;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & w_aw_open;
    slv_resp_o.w_ready  = mst_resp_i.w_ready & w_w_open;
  end

  dram_txn_counter #(.Max(MaxReadTxns), .Width(RdW)) u_rd_cnt (
    .i_clk       (clk_i),
    .i_rst_n     (rst_ni),
    .i_inc       (w_ar_hs),
    .i_dec       (w_r_last_hs),
    .o_count     (w_rd_cnt),
    .o_at_max    (w_rd_at_max),
    .o_is_zero   (w_rd_zero),
    .o_zero_next (w_rd_zero_next)
  );

  dram_txn_counter #(.Max(MaxWriteTxns), .Width(WrW)) u_wr_cnt (
    .i_clk       (clk_i),
    .i_rst_n     (rst_ni),
    .i_inc       (w_aw_hs),
    .i_dec       (w_b_hs),
    .o_count     (w_wr_cnt),
    .o_at_max    (w_wr_at_max),
    .o_is_zero   (w_wr_zero),
    .o_zero_next (w_wr_zero_next)
  );

  dram_txn_counter #(.Max(MaxWriteTxns), .Width(WrW)) u_wp_cnt (
    .i_clk       (clk_i),
    .i_rst_n     (rst_ni),
    .i_inc       (w_aw_hs),
    .i_dec       (w_w_last_hs),
    .o_count     (w_wp_cnt),
    .o_at_max    (w_wp_at_max),
    .o_is_zero   (w_wp_zero),
    .o_zero_next (w_wp_zero_next)
  );

  // Idle as of the next cycle, so ack rises right after the last response.
  assign w_idle_next = w_rd_zero_next & w_wr_zero_next & w_wp_zero_next &
                       ~w_ar_sticky_d & ~w_aw_sticky_d;

  always_comb begin
    w_state_next      = r_state;
    w_ret_next        = r_ret;
    w_calib_lost_next = r_calib_lost;
    w_stable_next     = '0;
    case (r_state)
      CALIB: begin
        if (calib_done_i) begin
          if (r_stable_cnt == StableLast) begin
            w_state_next = RUN;
          end else begin
            w_stable_next = r_stable_cnt + StW'(1);
          end
        end
      end
      RUN: begin
        if (!calib_done_i) begin
          w_state_next      = DRAIN;
          w_ret_next        = RET_CALIB;
          w_calib_lost_next = 1'b1;
        end else if (drain_req_i) begin
          w_state_next = DRAIN;
          w_ret_next   = RET_DRAINED;
        end
      end
      DRAIN: begin
        if (w_idle_next) begin
          w_state_next = (r_ret == RET_CALIB) ? CALIB : DRAINED;
        end
      end
      DRAINED: begin
        if (!drain_req_i) begin
          w_state_next = calib_done_i ? RUN : CALIB;
        end else if (!calib_done_i) begin
          w_state_next      = CALIB;
          w_calib_lost_next = 1'b1;
        end
      end
      default: w_state_next = CALIB;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= CALIB;
      r_ret        <= RET_CALIB;
      r_calib_lost <= 1'b0;
      r_stable_cnt <= '0;
      r_ar_sticky  <= 1'b0;
      r_aw_sticky  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_ret        <= w_ret_next;
      r_calib_lost <= w_calib_lost_next;
      r_stable_cnt <= w_stable_next;
      r_ar_sticky  <= w_ar_sticky_d;
      r_aw_sticky  <= w_aw_sticky_d;
    end
  end

  assign drain_ack_o      = (r_state == DRAINED);
  assign calib_lost_o     = r_calib_lost;
  assign rd_outstanding_o = w_rd_cnt;
  assign wr_outstanding_o = w_wr_cnt;
  assign dbg_state_o      = r_state;

  a_drained_idle : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_state == DRAINED) |-> (w_rd_zero && w_wr_zero && w_wp_zero));
  a_wpend_bounded : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (w_wp_cnt <= w_wr_cnt) && (!w_wp_at_max || w_wr_at_max));

endmodule

// File: doc/dram_traffic_gate.md
# dram_traffic_gate

AXI traffic controller between the SoC-side DRAM AXI path and the MIG AXI slave, in the DRAM AXI clock domain after the last spill stage. Holds off all traffic until PHY calibration is stable, bounds outstanding read/write transactions, and implements a drain handshake that quiesces the port before DRAM reset, self-refresh or reconfiguration. Adds no cycles to the datapath: all gating is on valid/ready.

## Interface
Parameters:
- axi_req_t, logic: AXI request struct (codebase AXI typedef).
- axi_resp_t, logic: AXI response struct.
- MaxReadTxns, 8: maximum outstanding AR bursts, ≥1.
- MaxWriteTxns, 8: maximum outstanding AW bursts, ≥1.
- CalibStableCycles, 16: consecutive cycles calib_done_i must be high before traffic opens, ≥1.

Ports:
- clk_i  in  1  DRAM AXI clock.
- rst_ni  in  1  reset; synchronous, active-low.
- slv_req_i  in  axi_req_t  upstream request.
- slv_resp_o  out  axi_resp_t  upstream response.
- mst_req_o  out  axi_req_t  request to MIG.
- mst_resp_i  in  axi_resp_t  response from MIG.
- calib_done_i  in  1  MIG init_calib_complete.
- drain_req_i  in  1  level request to quiesce.
- drain_ack_o  out  1  high while quiesced (DRAINED).
- calib_lost_o  out  1  sticky: calibration dropped while in RUN.
- rd_outstanding_o  out  $clog2(MaxReadTxns+1)  read counter.
- wr_outstanding_o  out  $clog2(MaxWriteTxns+1)  write counter.

## Operation
- FSM states: CALIB (reset), RUN, DRAIN, DRAINED.
- CALIB: stable counter increments while calib_done_i=1, clears when 0; at CalibStableCycles → RUN. AW/AR/W blocked.
- RUN: AW/AR gated only by counter limits. calib_done_i=0 → set calib_lost_o, go DRAIN with return target CALIB. drain_req_i=1 → DRAIN with return target DRAINED.
- DRAIN: new AW/AR blocked; W, B, R continue. When rd_cnt=0, wr_cnt=0, w_pend=0 → return target.
- DRAINED: drain_ack_o=1; all blocked. drain_req_i=0 → RUN if calib_done_i=1, else CALIB (stable counter cleared). Loss of calib in DRAINED → CALIB, calib_lost_o set.
- rd_cnt: +1 on AR handshake, −1 on R handshake with last. wr_cnt: +1 on AW handshake, −1 on B handshake. w_pend: +1 on AW handshake, −1 on W handshake with last. Simultaneous inc/dec → unchanged.
- AR open iff state=RUN and rd_cnt<MaxReadTxns (registered values). AW likewise with wr_cnt<MaxWriteTxns.
- Sticky grant: once mst ar_valid/aw_valid has been presented without ready, gate stays open until handshake regardless of state/count (AXI valid stability toward MIG).
- W forwarded only while w_pend>0 or AW handshake occurs same cycle; W never precedes its AW downstream.
- Gated channel: mst valid=0 and slv ready=0. Payloads pass through unchanged. B and R always passed.
- Counter overflow/underflow is unreachable by construction; assertion-checked.

## Timing
- Zero-cycle combinational valid/ready/payload paths; no registers in datapath.
- State transitions take effect the cycle after the condition is sampled.
- drain_ack_o rises the cycle after the last outstanding response handshake; falls the cycle after drain_req_i falls.
- CALIB→RUN: first AR/AW accepted CalibStableCycles+1 cycles after calib_done_i rises.
- Reset (including mid-burst): state CALIB, all counters 0, calib_lost_o=0, drain_ack_o=0, all mst valids and slv readies 0 in the reset cycle and until RUN; in-flight MIG responses are dropped (MIG is reset together).

## Structure
- dram_ctrl_pkg: gate_state_e enum {CALIB, RUN, DRAIN, DRAINED}, return-target enum.
- Sub-module dram_txn_counter (parameterised width/max, inc/dec, at_max/is_zero flags), instantiated three times.
- Top holds FSM, stable counter, sticky grant flags, channel muxing.

## Test plan
- Calib glitch: calib_done_i high 10 cycles, low 1, high 16 → AR held; accepted exactly cycle 17 after final rise.
- Limit: MaxReadTxns=8, 9 back-to-back ARs, MIG withholds R → 8 accepted, 9th stalls with slv ar_ready=0; one R last → 9th accepted next cycle.
- Drain: 3 writes outstanding, drain_req_i=1 → new AW blocked; after 3rd B, drain_ack_o=1 next cycle; drain_req_i=0 → RUN, AW accepted.
- Sticky grant: AW presented, MIG ready low, drain_req_i rises → mst aw_valid stays high until handshake; wr_cnt=1 then drains.
- W ordering: W beats before AW → mst w_valid=0; AW accepted len=3 → exactly 4 beats forwarded, w_pend returns 0.
- Calib loss in RUN with 2 reads outstanding → calib_lost_o=1, R completes, state CALIB, rst_ni low clears calib_lost_o.
